// File: rtl/usb_bus_ctrl_if.sv
// usb_bus_ctrl_if: CPU command/response bus plus ISP1760 chip pins of usb_bus_ctrl.
interface usb_bus_ctrl_if;
  logic        mem_cmd_sel, mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
  logic [18:0] mem_cmd_addr;
  logic [31:0] mem_cmd_wdata;
  logic [3:0]  mem_cmd_be;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        usb_reset_, usb_cs_, usb_rd_, usb_wr_, usb_d_oe, usb_irq, usb_irq_sync;
  logic [16:0] usb_a;
  logic [15:0] usb_d_out, usb_d_in;
  modport slave (
    input  mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_be,
           usb_d_in, usb_irq,
    output mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata, usb_reset_, usb_cs_, usb_rd_, usb_wr_,
           usb_a, usb_d_oe, usb_d_out, usb_irq_sync
  );
  modport master (
    output mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata, mem_cmd_be,
           usb_d_in, usb_irq,
    input  mem_cmd_ready, mem_rsp_ready, mem_rsp_rdata, usb_reset_, usb_cs_, usb_rd_, usb_wr_,
           usb_a, usb_d_oe, usb_d_out, usb_irq_sync
  );
endinterface

// File: rtl/usb_bus_ctrl.sv
// usb_bus_ctrl: CPU-bus slave that turns 32-bit accesses into timed 16-bit ISP1760 bus cycles,
// and holds the chip-reset control register and the interrupt synchronizer.
module usb_bus_ctrl #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned GAP_CYC    = 2
) (
  input logic           clk,
  input logic           reset_,
  usb_bus_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, STROBE = 3'd2, HOLD = 3'd3, GAP = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hi_q, hi_d, need_hi_q, need_hi_d, wr_q, wr_d, ctrl_q, ctrl_d;
  logic        irq_m_q, irq_m_d, irq_sync_q, irq_sync_d, rsp_q, rsp_d;
  logic        cs_q, cs_d, rd_q, rd_d, wrs_q, wrs_d, oe_q, oe_d;
  logic [15:0] addr_q, addr_d, dout_q, dout_d;
  logic [16:0] a_q, a_d;
  logic [31:0] wdata_q, wdata_d, cap_q, cap_d, rdata_q, rdata_d;
  logic        accept, local_acc, last, enter, reg_bit;
  always_comb begin
    accept    = bus.mem_cmd_valid & bus.mem_cmd_sel & (state_q == IDLE);
    local_acc = accept & bus.mem_cmd_addr[18];
    wr_d      = accept ? bus.mem_cmd_wr : wr_q;
    addr_d    = accept ? bus.mem_cmd_addr[17:2] : addr_q;
    wdata_d   = accept ? bus.mem_cmd_wdata : wdata_q;
    need_hi_d = accept ? (!bus.mem_cmd_wr | (|bus.mem_cmd_be[3:2])) : need_hi_q;
    last      = cnt_q == 4'd1;
    state_d   = state_q;
    cnt_d     = cnt_q - 4'd1;
    hi_d      = hi_q;
    if (state_q == IDLE) begin
      cnt_d = 4'(SETUP_CYC);
      // a write with no byte enables never leaves IDLE
      if (accept & !bus.mem_cmd_addr[18] & (!bus.mem_cmd_wr | (|bus.mem_cmd_be))) begin
        state_d = SETUP;
        hi_d    = bus.mem_cmd_wr & ~|bus.mem_cmd_be[1:0];
      end
    end else if (last) begin
      state_d = state_q == SETUP  ? STROBE :
                state_q == STROBE ? HOLD :
                state_q == HOLD   ? GAP :
                (!hi_q & need_hi_q) ? SETUP : IDLE;
      cnt_d   = state_d == STROBE ? 4'(STROBE_CYC) :
                state_d == HOLD   ? 4'(HOLD_CYC) :
                state_d == GAP    ? 4'(GAP_CYC) : 4'(SETUP_CYC);
      hi_d    = state_q == GAP ? 1'b1 : hi_q;
    end
    enter  = (state_d == SETUP) & (state_q != SETUP);
    a_d    = enter ? {addr_d, hi_d} : a_q;
    dout_d = enter ? (hi_d ? wdata_d[31:16] : wdata_d[15:0]) : dout_q;
    // chip strobes come straight from flops so the asynchronous bus never sees decode glitches
    cs_d   = !((state_d == SETUP) | (state_d == STROBE) | (state_d == HOLD));
    rd_d   = !((state_d == STROBE) & !wr_d);
    wrs_d  = !((state_d == STROBE) & wr_d);
    oe_d   = !cs_d & wr_d;
    cap_d  = (state_q == STROBE) & last ?
             (hi_q ? {bus.usb_d_in, cap_q[15:0]} : {cap_q[31:16], bus.usb_d_in}) : cap_q;
    reg_bit = bus.mem_cmd_addr[17:2] == 16'd0 ? ctrl_q :
              bus.mem_cmd_addr[17:2] == 16'd1 ? irq_sync_q : 1'b0;
    rsp_d   = (local_acc & !bus.mem_cmd_wr) | ((state_q == HOLD) & last & hi_q & !wr_q);
    rdata_d = local_acc & !bus.mem_cmd_wr ? {31'b0, reg_bit} : rsp_d ? cap_q : rdata_q;
    ctrl_d  = local_acc & bus.mem_cmd_wr & bus.mem_cmd_be[0] & (bus.mem_cmd_addr[17:2] == 16'd0) ?
              bus.mem_cmd_wdata[0] : ctrl_q;
    irq_m_d    = bus.usb_irq;
    irq_sync_d = irq_m_q;
  end
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hi_q       <= 1'b0;
      need_hi_q  <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= 1'b0;
      irq_m_q    <= 1'b0;
      irq_sync_q <= 1'b0;
      cap_q      <= '0;
      rdata_q    <= '0;
      rsp_q      <= 1'b0;
      cs_q       <= 1'b1;
      rd_q       <= 1'b1;
      wrs_q      <= 1'b1;
      oe_q       <= 1'b0;
      a_q        <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      need_hi_q  <= need_hi_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctrl_q     <= ctrl_d;
      irq_m_q    <= irq_m_d;
      irq_sync_q <= irq_sync_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      rsp_q      <= rsp_d;
      cs_q       <= cs_d;
      rd_q       <= rd_d;
      wrs_q      <= wrs_d;
      oe_q       <= oe_d;
      a_q        <= a_d;
      dout_q     <= dout_d;
    end
  end
  assign bus.mem_cmd_ready = state_q == IDLE;
  assign bus.mem_rsp_ready = rsp_q;
  assign bus.mem_rsp_rdata = rdata_q;
  assign bus.usb_reset_    = ctrl_q;
  assign bus.usb_cs_       = cs_q;
  assign bus.usb_rd_       = rd_q;
  assign bus.usb_wr_       = wrs_q;
  assign bus.usb_a         = a_q;
  assign bus.usb_d_oe      = oe_q;
  assign bus.usb_d_out     = dout_q;
  assign bus.usb_irq_sync  = irq_sync_q;
endmodule

// File: doc/usb_bus_ctrl.md
# usb_bus_ctrl

CPU-bus slave that replaces the tied-off USB stub in `soc` and drives the ISP1760 USB host controller's asynchronous 16-bit parallel bus. It decodes the `0xF02xxxxx` window. Each 32-bit CPU access becomes one or two timed 16-bit chip cycles. The block stalls the CPU bus while a chip cycle is in progress and returns read data through the shared response path. It also holds the chip-reset control register and synchronizes the chip interrupt.

## Interface
Parameters:
- SETUP_CYC, 1: cycles with `usb_cs_` low and address valid before the strobe; range 1..15.
- STROBE_CYC, 3: cycles `usb_rd_`/`usb_wr_` held low; range 1..15.
- HOLD_CYC, 1: cycles after the strobe rises with `usb_cs_` still low and write data still driven; range 1..15.
- GAP_CYC, 2: cycles `usb_cs_` is held high after every 16-bit cycle; range 1..15.

Ports:
- clk  in  1  system clock; the only clock.
- reset_  in  1  asynchronous, active-low reset.
- mem_cmd_sel  in  1  address decode hit (`addr[31:20]==12'hf02`).
- mem_cmd_valid  in  1  command valid.
- mem_cmd_ready  out  1  command accept; high only in IDLE.
- mem_cmd_wr  in  1  1 = write.
- mem_cmd_addr  in  19  byte address `[18:0]`.
- mem_cmd_wdata  in  32  write data.
- mem_cmd_be  in  4  byte enables.
- mem_rsp_ready  out  1  one-cycle read-data-valid pulse.
- mem_rsp_rdata  out  32  read data.
- usb_reset_  out  1  chip reset, active low.
- usb_cs_, usb_rd_, usb_wr_  out  1 each  chip strobes, active low.
- usb_a  out  17  chip address `[17:1]`.
- usb_d_oe  out  1  tristate enable for `usb_d`; the pad is tristated at top level.
- usb_d_out  out  16  write data toward the pad.
- usb_d_in  in  16  read data from the pad.
- usb_irq  in  1  asynchronous chip interrupt, active high.
- usb_irq_sync  out  1  `usb_irq` after a 2-flop synchronizer.

## Operation
- A command is accepted when `mem_cmd_valid & mem_cmd_sel & mem_cmd_ready`.
  - On acceptance, `addr`, `wdata`, `be` and `wr` are latched.
  - A command arriving while busy is not accepted; the CPU holds it.
- `addr[18]==1`: local register access with no chip cycle.
  - Offset 0x0, CTRL (R/W): bit0 drives `usb_reset_`. The reset value is 0, so the chip is held in reset. A write updates CTRL only when `be[0]` is set.
  - Offset 0x4, STATUS (RO): bit0 is `usb_irq_sync`. Writes are ignored.
  - Unused bits read as 0.
- `addr[18]==0`: chip access.
  - Low half: `usb_a = {addr[17:2],1'b0}`, data `[15:0]`.
  - High half: `usb_a = {addr[17:2],1'b1}`, data `[31:16]`.
  - Reads always perform both halves, low half first, and return `{hi,lo}`.
  - Writes skip the low half if `be[1:0]==0` and skip the high half if `be[3:2]==0`.
  - A write with `be==0` is accepted with no chip cycle and returns to IDLE on the next cycle.
- FSM states: IDLE → SETUP → STROBE → HOLD → GAP → (SETUP of the high half | IDLE).
  - One 4-bit down-counter is loaded with the parameter value on each state entry.
  - The state advances when the counter reaches 1.
- Chip pin behaviour per state:
  - `usb_cs_` is low in SETUP, STROBE and HOLD, and high otherwise.
  - `usb_rd_` or `usb_wr_` is low only in STROBE.
  - `usb_d_oe` is 1 in SETUP, STROBE and HOLD of writes only.
  - `usb_a` and `usb_d_out` are registered and stay stable from SETUP through HOLD.
- `usb_d_in` is captured on the clock edge that ends the last STROBE cycle.

## Timing
- Reset values:
  - `mem_rsp_ready=0`, `mem_rsp_rdata=0`.
  - `usb_cs_=usb_rd_=usb_wr_=1`, `usb_a=0`.
  - `usb_d_oe=0`, `usb_d_out=0`.
  - `usb_reset_=0`, `usb_irq_sync=0`.
  - FSM in IDLE, so `mem_cmd_ready=1`.
- Local register read: `mem_rsp_ready` pulses for 1 cycle, in the cycle after acceptance. `mem_cmd_ready` stays high.
- Cycle arithmetic: one half takes H = SETUP+STROBE+HOLD cycles; with defaults H=5.
- 32-bit chip read with defaults:
  - Acceptance occurs at edge 0.
  - Cycles 1-5 are the low half, 6-7 are GAP, 8-12 are the high half.
  - `mem_rsp_ready` is high in cycle 13 only.
  - `mem_cmd_ready` returns high in cycle 15.
- 32-bit chip write with defaults: `mem_cmd_ready` returns high in cycle 15. A write with only one half enabled returns it in cycle 8.
- `mem_rsp_ready` is never asserted for writes.
- Reset asserted mid-operation:
  - All outputs immediately take their reset values and the FSM returns to IDLE.
  - A pending read produces no response.
  - CTRL returns to 0, so the chip is reset.

## Test plan
- Reset, then read offset 0x4_0000 (CTRL) → rdata 0 in cycle 1 and `usb_reset_=0`. Write 1 to CTRL → `usb_reset_=1` in the next cycle.
- Read chip address 0x0300 with `usb_d_in` = 0x1234 on the low half and 0xABCD on the high half → `usb_a` is 0x180 then 0x181; strobes match the default cycle counts; rdata is 0xABCD1234 in cycle 13.
- Write 0xCAFE_BEEF to 0x0304 with `be=4'b1100` → only the high half occurs, at `usb_a=0x183` with `usb_d_out=0xCAFE`; `usb_d_oe` is high for cycles 1-5; ready returns in cycle 8.
- Hold a second command valid during a busy chip read → it is not accepted until cycle 15, and its first SETUP starts in cycle 16.
- Toggle `usb_irq` → `usb_irq_sync` and STATUS bit0 follow 2 cycles later. Assert `reset_` in cycle 3 of a read → pins are idle at once and no `mem_rsp_ready` occurs.
